bpred_resolve_unit: RTL

- Resolution-side partner of the bimodal predictor.
- Records each direction prediction issued at fetch in an in-order in-flight queue.
- When a branch resolves in decode, compares actual against predicted outcome, emits the registered predictor update (write/taken/pc) and, on mispredict, a flush plus redirect PC.
- Sits between the fetch stage, the decode-stage branch compare, and the predictor's update port.

---
 rtl/bpred_resolve_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/bpred_resolve_unit.sv
// bpred_resolve_unit: in-flight branch prediction queue and resolve/update/flush logic; BPRED_STATS_EN adds resolve/mispredict counters.
module bpred_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int INDEX_SIZE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        stall_fetch,
  output logic        upd_write,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
`ifdef BPRED_STATS_EN
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred,
`endif
  output logic        underflow_err
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || INDEX_SIZE < 1) begin : g_cfg_chk
    $error("bpred_resolve_unit: DEPTH must be a power of two >= 2");
  end
  logic [31:0]    pc_q [DEPTH];
  logic [31:0]    tgt_q [DEPTH];
  logic [DEPTH-1:0] tk_q;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [AW:0]    count_q, count_d;
  logic           upd_write_q, upd_taken_q, flush_q, uf_q;
  logic [31:0]    upd_pc_q, redirect_q;
  logic           pop, mis, push;
  assign stall_fetch = count_q == (AW+1)'(DEPTH);
  assign pop  = res_valid && count_q != '0;
  assign mis  = pop && (res_taken != tk_q[head_q] || res_target != tgt_q[head_q]);
  // A pop frees the slot in the same cycle, so a full queue can still accept
  // a push; anything younger than a mispredicted branch is dropped.
  assign push = pred_valid && !mis && (!stall_fetch || pop);
  always_comb begin
    head_d  = mis ? '0 : pop ? head_q + 1'b1 : head_q;
    tail_d  = mis ? '0 : push ? tail_q + 1'b1 : tail_q;
    count_d = mis ? '0 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]  <= pred_pc;
      tk_q[tail_q]  <= pred_taken;
      tgt_q[tail_q] <= pred_target;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_write_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      uf_q        <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_write_q <= pop;
      upd_pc_q    <= pop ? pc_q[head_q] : '0;
      upd_taken_q <= pop && res_taken;
      flush_q     <= mis;
      if (mis) redirect_q <= res_target;
      if (res_valid && !pop) uf_q <= 1'b1;
    end
  end
  assign upd_write     = upd_write_q;
  assign upd_pc        = upd_pc_q;
  assign upd_taken     = upd_taken_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign underflow_err = uf_q;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_res_q, stat_mis_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (pop && stat_res_q != '1) stat_res_q <= stat_res_q + 32'd1;
      if (mis && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end
  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif
endmodule
